// File: rtl/fma_issue_ctrl_if.sv
// fma_issue_ctrl_if: requester, FMA-result and writeback signals.
// slave is the controller view, master the surrounding pipeline view.
interface fma_issue_ctrl_if #(
  parameter int TAG_W = 10
);
  logic [1:0]       req_valid;
  logic [TAG_W-1:0] req_tag0;
  logic [TAG_W-1:0] req_tag1;
  logic [1:0]       req_ready;
  logic             fma_issue;
  logic             fma_sel;
  logic [31:0]      fma_result;
  logic             flush;
  logic             wb_valid;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_src;
  logic             wb_ready;
  logic             busy;

  modport slave (
    input  req_valid, req_tag0, req_tag1,
    input  fma_result, flush, wb_ready,
    output req_ready, fma_issue, fma_sel,
    output wb_valid, wb_data, wb_tag, wb_src,
    output busy
  );

  modport master (
    output req_valid, req_tag0, req_tag1,
    output fma_result, flush, wb_ready,
    input  req_ready, fma_issue, fma_sel,
    input  wb_valid, wb_data, wb_tag, wb_src,
    input  busy
  );
endinterface

// File: rtl/fma_issue_ctrl.sv
// fma_issue_ctrl: 2-way round-robin FMA issue with credit-gated result FIFO.
// Optional FMA_ISSUE_CTRL_BYPASS_EN forwards a result straight to writeback.
module fma_issue_ctrl #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 10,
  parameter int DEPTH   = 6
) (
  input logic clk,
  input logic rst_n,
  fma_issue_ctrl_if.slave bus
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             src;
  } meta_t;

  typedef struct packed {
    logic [31:0] data;
    meta_t       meta;
  } ent_t;

  logic [OW-1:0]      occ;
  logic [OW-1:0]      fcnt;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic               prio;
  logic               sel_q;
  logic [LATENCY-1:0] sr_v;
  meta_t              sr_m [LATENCY];
  ent_t               mem [DEPTH];

  logic       can_issue;
  logic [1:0] gnt;
  logic       issue;
  meta_t      in_m;
  ent_t       res;
  ent_t       head;
  ent_t       out;
  logic       fvalid;
  logic       arrive;
  logic       byp;
  logic       push;
  logic       pop;
  logic       fpop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check uses registered occ, so a pop frees a slot next cycle.
  assign can_issue = rst_n && !bus.flush
                  && (occ < OW'(DEPTH));

  always_comb begin
    gnt = 2'b00;
    if (can_issue) begin
      if (&bus.req_valid) begin
        gnt = prio ? 2'b10 : 2'b01;
      end else begin
        gnt = bus.req_valid;
      end
    end
  end

  assign issue         = |gnt;
  assign bus.req_ready = gnt;
  assign bus.fma_issue = issue;
  assign bus.fma_sel   = issue ? gnt[1] : sel_q;
  assign bus.busy      = (occ != '0);

  assign in_m.tag = gnt[1] ? bus.req_tag1
                           : bus.req_tag0;
  assign in_m.src = gnt[1];

  assign res.data = bus.fma_result;
  assign res.meta = sr_m[LATENCY-1];
  assign head     = mem[rd_ptr];

  assign fvalid = (fcnt != '0);
  assign arrive = sr_v[LATENCY-1] && !bus.flush;

`ifdef FMA_ISSUE_CTRL_BYPASS_EN
  assign byp = arrive && !fvalid && bus.wb_ready;
`else
  assign byp = 1'b0;
`endif

  assign push = arrive && !byp;
  assign out  = fvalid ? head
              : (byp ? res : '0);

  assign bus.wb_valid = fvalid || byp;
  assign bus.wb_data  = out.data;
  assign bus.wb_tag   = out.meta.tag;
  assign bus.wb_src   = out.meta.src;

  assign pop  = bus.wb_valid && bus.wb_ready;
  assign fpop = pop && fvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= '0;
      fcnt   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      prio   <= 1'b0;
      sel_q  <= 1'b0;
      sr_v   <= '0;
    end else begin
      if (issue) begin
        prio  <= ~gnt[1];
        sel_q <= gnt[1];
      end
      // Flush keeps the priority pointer.
      if (bus.flush) begin
        occ    <= '0;
        fcnt   <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        sr_v   <= '0;
      end else begin
        occ  <= occ + OW'(issue) - OW'(pop);
        fcnt <= fcnt + OW'(push) - OW'(fpop);
        if (push) wr_ptr <= nxt(wr_ptr);
        if (fpop) rd_ptr <= nxt(rd_ptr);
        for (int i = LATENCY - 1; i > 0; i--) begin
          sr_v[i] <= sr_v[i-1];
        end
        sr_v[0] <= issue;
      end
    end
  end

  always_ff @(posedge clk) begin
    sr_m[0] <= in_m;
    for (int i = 1; i < LATENCY; i++) begin
      sr_m[i] <= sr_m[i-1];
    end
    if (push) mem[wr_ptr] <= res;
  end
endmodule

// File: tb/tb_fma_issue_ctrl.sv
// tb_fma_issue_ctrl: directed + random stimulus against a queue-based
// reference of issued-but-undelivered ops.
module tb_fma_issue_ctrl;
  localparam int LAT   = 4;
  localparam int TAG_W = 10;
  localparam int DEPTH = 6;
`ifdef FMA_ISSUE_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             src;
    logic [31:0]      data;
    int               cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fma_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fma_issue_ctrl #(
    .LATENCY(LAT),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t        q[$];
  logic [31:0] fres[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic        prio_m = 1'b0;
  logic        sel_m  = 1'b0;

  function automatic void chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  function automatic logic [TAG_W-1:0] rt();
    return TAG_W'($urandom);
  endfunction

  // One clock of stimulus; grant/issue expectations come from the
  // outstanding-op count, the model's round-robin pointer and the inputs.
  task automatic step(
    input logic [1:0]       v,
    input logic [TAG_W-1:0] t0,
    input logic [TAG_W-1:0] t1,
    input logic             wr,
    input logic             fl,
    input logic             rn
  );
    logic [1:0] er;
    exp_t       e;
    @(posedge clk);
    #1;
    cyc++;
    rst_n          = rn;
    bus.req_valid  = v;
    bus.req_tag0   = t0;
    bus.req_tag1   = t1;
    bus.wb_ready   = wr;
    bus.flush      = fl;
    bus.fma_result = fres.pop_front();
    @(negedge clk);
    er = 2'b00;
    if (!rn) begin
      prio_m = 1'b0;
      sel_m  = 1'b0;
    end else if (q.size() < DEPTH && !fl) begin
      if (v == 2'b11) er = prio_m ? 2'b10 : 2'b01;
      else            er = v;
    end
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("fma_issue", 64'(bus.fma_issue), 64'(|er));
    if (er != 2'b00) begin
      sel_m  = er[1];
      prio_m = ~er[1];
    end
    chk("fma_sel", 64'(bus.fma_sel), 64'(sel_m));
    chk("busy", 64'(bus.busy),
        64'(rn && q.size() != 0));
    e.data = $urandom;
    if (er != 2'b00) begin
      e.tag = er[1] ? t1 : t0;
      e.src = er[1];
      e.cyc = cyc;
      q.push_back(e);
    end
    fres.push_back(e.data);
  endtask

  task automatic idle(input int n, input logic wr);
    repeat (n) step(2'b00, '0, '0, wr, 1'b0, 1'b1);
  endtask

  // Monitor: the head op must be presented exactly once its result
  // has had time to land, with the data the FMA returned for it.
  initial begin
    exp_t h;
    bit   mat;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_wb", 64'({bus.wb_valid, bus.wb_src,
                           bus.wb_tag, bus.wb_data}), 64'(0));
        q.delete();
      end else begin
        mat = 1'b0;
        if (q.size() != 0) begin
          h   = q[0];
          mat = (cyc >= h.cyc + LAT + 1)
             || (BYP && cyc == h.cyc + LAT
                 && bus.wb_ready && !bus.flush);
        end
        chk("wb_valid", 64'(bus.wb_valid), 64'(mat));
        if (mat && bus.wb_valid) begin
          chk("wb_data", 64'(bus.wb_data), 64'(h.data));
          chk("wb_tag", 64'(bus.wb_tag), 64'(h.tag));
          chk("wb_src", 64'(bus.wb_src), 64'(h.src));
          if (bus.wb_ready) void'(q.pop_front());
        end
        if (bus.flush) q.delete();
      end
    end
  end

  initial begin
    int pct;
    bus.req_valid  = 2'b00;
    bus.req_tag0   = '0;
    bus.req_tag1   = '0;
    bus.wb_ready   = 1'b0;
    bus.flush      = 1'b0;
    bus.fma_result = '0;
    repeat (LAT) fres.push_back($urandom);

    repeat (3) step(2'b11, rt(), rt(), 1'b1, 1'b0, 1'b0);

    for (int i = 1; i <= 8; i++) begin
      step(2'b01, TAG_W'(i), rt(), 1'b1, 1'b0, 1'b1);
    end
    idle(8, 1'b1);

    step(2'b10, rt(), rt(), 1'b1, 1'b0, 1'b1);
    repeat (6) step(2'b11, rt(), rt(), 1'b1, 1'b0, 1'b1);
    idle(10, 1'b1);

    repeat (12) step(2'b11, rt(), rt(), 1'b0, 1'b0, 1'b1);
    step(2'b11, rt(), rt(), 1'b1, 1'b0, 1'b1);
    repeat (3) step(2'b11, rt(), rt(), 1'b0, 1'b0, 1'b1);
    idle(14, 1'b1);

    repeat (2) step(2'b01, rt(), rt(), 1'b0, 1'b0, 1'b1);
    idle(LAT + 1, 1'b0);
    repeat (3) step(2'b10, rt(), rt(), 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    step(2'b00, '0, '0, 1'b0, 1'b1, 1'b1);
    idle(8, 1'b1);

    repeat (4) step(2'b01, rt(), rt(), 1'b1, 1'b0, 1'b1);
    step(2'b11, rt(), rt(), 1'b1, 1'b0, 1'b0);
    idle(LAT + 3, 1'b1);

    pct = 90;
    for (int i = 0; i < 3000; i++) begin
      logic fl;
      logic rn;
      logic wr;
      if (i % 500 == 0) pct = $urandom_range(5, 100);
      fl = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 299) != 0);
      wr = ($urandom_range(0, 99) < pct);
      step(2'($urandom), rt(), rt(), wr, fl, rn);
    end
    idle(LAT + DEPTH + 4, 1'b1);
    chk("drained", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fma_issue_ctrl.md
FMA_ISSUE_CTRL -- requirements
Module: fma_issue_ctrl

Interface
REQ-001 Parameter: LATENCY, 4, fixed FMA pipeline depth in cycles (at least 1).
REQ-002 Parameter: TAG_W, 10, width of the destination+ticket tag carried alongside each op.
REQ-003 Parameter: DEPTH, 6, result buffer entries; at least 1; full throughput requires at least LATENCY+2.
REQ-004 Port: clk  in  1  single clock, rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: req_valid  in  2  per-requester op valid.
REQ-007 Port: req_tag0 / req_tag1  in  TAG_W each  per-requester tag.
REQ-008 Port: req_ready  out  2  one-hot grant; an op issues when req_valid[i] and req_ready[i] are both high.
REQ-009 Port: fma_issue  out  1  an op enters the FMA this cycle.
REQ-010 Port: fma_sel  out  1  operand-mux select, naming the granted requester.
REQ-011 Port: fma_result  in  32  FMA result, valid LATENCY cycles after issue.
REQ-012 Port: flush  in  1  synchronous kill of all in-flight and buffered ops.
REQ-013 Port: wb_valid / wb_data / wb_tag / wb_src  out  1 / 32 / TAG_W / 1  writeback result, tag and requester index.
REQ-014 Port: wb_ready  in  1  writeback accept; a pop occurs when wb_valid and wb_ready are both high.
REQ-015 Port: busy  out  1  high when occ is non-zero.

Function
REQ-016 occ is a counter of ops issued but not yet popped, holding values 0..DEPTH; issue is permitted only when the registered occ is below DEPTH and flush is low.
REQ-017 occ update per cycle: +1 on issue, -1 on pop, unchanged when both occur; a credit freed by a pop is usable from the next cycle.
REQ-018 Arbitration: round-robin with a 1-bit priority pointer.
- A single valid requester is granted.
- When both are valid, the requester named by the pointer is granted.
- The pointer moves to the other requester only after an issue.
REQ-019 req_ready is all-zero when issue is not permitted; req_ready may depend combinationally on req_valid.
REQ-020 fma_issue equals the OR of the req_valid & req_ready bits; fma_sel equals the granted index and holds its previous value when idle.
REQ-021 A LATENCY-stage shift register carries {valid, tag, src} in lockstep with the FMA.
REQ-022 Results: an op issued in cycle t is written into the FIFO with fma_result at the end of cycle t+LATENCY; wb_valid asserts from cycle t+LATENCY+1.
REQ-023 The FIFO is in-order with a wrapping read/write pointer pair; a push and pop in the same cycle are both honoured, including when the FIFO is full.
REQ-024 Credit gating makes FIFO overflow impossible; wb_* outputs are held stable while wb_valid is high and wb_ready is low.
REQ-025 Flush behaviour:
- Clears the shift register valids, the FIFO and occ, and blocks issue in that cycle.
- A result arriving in the flush cycle is dropped.
- A wb handshake in the flush cycle counts as delivered.
- The priority pointer is preserved.

Reset
REQ-026 While rst_n is low, the following are zero: occ, FIFO pointers, shift register valids, priority pointer (requester 0 first), req_ready, fma_issue, fma_sel, wb_valid, wb_data, wb_tag, wb_src and busy.
REQ-027 Reset asserted mid-operation discards all in-flight ops; results returned by the FMA after reset release are ignored.

Configuration
REQ-028 Macro FMA_ISSUE_CTRL_BYPASS_EN, when defined: a result arriving with the FIFO empty and wb_ready high drives wb_* combinationally in cycle t+LATENCY and is not pushed.
- If wb_ready is low in that cycle, the result is pushed normally.
REQ-029 Without FMA_ISSUE_CTRL_BYPASS_EN: issue-to-wb_valid latency is always LATENCY+1 and wb_* are driven from registers only.

Verification
REQ-030 Back-to-back requester 0 issues with wb_ready=1, tags 0x001..0x008 -> one issue per cycle, wb_tag 0x001..0x008 in order, first wb_valid at cycle 5 (cycle 4 with bypass), wb_src=0.
REQ-031 Both requesters valid for 6 cycles -> grants alternate 0,1,0,1,0,1 and fma_sel follows the grants.
REQ-032 wb_ready=0 with continuous requests -> exactly 6 issues, then req_ready=00 and busy=1.
- On the next cycle with wb_ready=1 -> one pop, then one new issue the cycle after.
REQ-033 Flush asserted 2 cycles after issuing 3 ops with the FIFO holding 2 -> wb_valid=0 and busy=0 the next cycle, and no stale result appears in the following 8 cycles.
REQ-034 rst_n pulsed low for one cycle while 4 ops are in flight -> all outputs zero, and no wb_valid for at least LATENCY+2 cycles after release.
